mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter and bus sequencer that shares the single external memory/MIO port between the pipeline's instruction-fetch (IF) stage and the data-access (MEM) stage of the RV32 pipelined CPU. It serializes requests, drives the address-latch/read-write handshake against the bus `Ready` line, and returns per-requester acknowledge and stall signals to the pipeline. It also aborts hung transfers with a wait-state timeout and exports the grant owner for the CPU test/debug mux.

## Interface
- `TIMEOUT`, 15: consecutive not-ready transfer cycles before abort (≥2)
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high
- `if_req`  in  1  IF read request; held until `if_ack`
- `if_addr`  in  32  IF word address
- `if_rdata`  out  32  fetched instruction, valid when `if_ack`
- `if_ack`  out  1  one-cycle completion pulse to IF
- `mem_req`  in  1  MEM request; held until `mem_ack`
- `mem_we`  in  1  1 = store, 0 = load
- `mem_addr`  in  32  data address
- `mem_wdata`  in  32  store data
- `mem_rdata`  out  32  load data, valid when `mem_ack`
- `mem_ack`  out  1  one-cycle completion pulse to MEM
- `bus_ale`  out  1  address-latch strobe, first transfer cycle only
- `bus_addr`  out  32  bus address
- `bus_wdata`  out  32  bus write data
- `bus_we`  out  1  bus write enable
- `bus_mio`  out  1  1 during data transfers, 0 during fetches
- `bus_ready`  in  1  slave ready (MIO_ready)
- `bus_rdata`  in  32  slave read data
- `stall_if`  out  1  `if_req & ~if_ack` (combinational)
- `stall_mem`  out  1  `mem_req & ~mem_ack` (combinational)
- `bus_err`  out  1  sticky timeout flag
- `err_clr`  in  1  clears `bus_err`
- `grant_owner`  out  2  debug: 00 none, 01 IF, 10 MEM

## Operation
- FSM states: IDLE, IF_XFER, MEM_XFER, DONE.
- IDLE: if exactly one request is pending, grant it. If both are pending, grant the one that is not `last_owner`. `last_owner` resets to IF, so MEM wins the first tie. On grant, latch addr, wdata and we, set `last_owner`, and go to the XFER state.
- XFER: `bus_addr`/`bus_wdata` come from the latched registers and are stable for the whole transfer.
  - `bus_ale`=1 only in the first XFER cycle.
  - `bus_we` = latched `mem_we` in MEM_XFER, else 0.
  - `bus_mio`=1 in MEM_XFER only.
  - `grant_owner` reflects the state.
- `bus_ready` is sampled every XFER cycle, including the first. When `bus_ready`=1, capture `bus_rdata` into the owner's rdata register (loads and fetches only; a store leaves `mem_rdata` unchanged) and go to DONE.
- Timeout: `wait_cnt` clears on XFER entry and increments on each XFER cycle with `bus_ready`=0. In the cycle where `bus_ready`=0 and `wait_cnt`==TIMEOUT-1:
  - abort and go to DONE;
  - load `if_rdata`=0x00000013 (NOP) or `mem_rdata`=0;
  - set `bus_err`.
  - If `bus_ready`=1 in the would-be abort cycle, ready wins: normal completion, no error.
- DONE: the owner's ack is 1 for exactly this cycle. The owner's req is ignored in this cycle. Next state is IDLE, where the other requester, or a re-asserted req, may be granted.
- `bus_err`: set on abort, cleared by `err_clr`; set wins if both occur in the same cycle.
- Idle values: `bus_ale`/`bus_we`/`bus_mio`=0; `bus_addr`/`bus_wdata` hold their last latched values.

## Timing
- Reset (async, immediate): state IDLE; every output 0 except the combinational stalls (which follow the reqs); `last_owner`=IF; `wait_cnt`=0; `bus_err`=0. A transfer in flight when reset asserts is discarded with no ack; the requester must reissue.
- Minimum latency: req seen in IDLE at cycle 0 → XFER at cycle 1 (ready=1) → ack at cycle 2 → IDLE at cycle 3. Back-to-back transfers therefore take 3 cycles each.
- Each not-ready cycle adds 1 cycle of latency. An abort acks at cycle TIMEOUT+1 after grant.
- Requesters must hold req, addr, wdata and we stable from assertion through the ack cycle. Changes after the grant are ignored.

## Test plan
- Single fetch: `if_req`=1, `if_addr`=0x100, `bus_ready`=1, `bus_rdata`=0x00A00093 → `bus_ale` at cycle 1 with `bus_addr`=0x100 and `bus_mio`=0; `if_ack`=1 and `if_rdata`=0x00A00093 at cycle 2; `stall_if` 1 during cycles 0–1.
- Store with wait states: `mem_req`=1, `mem_we`=1, addr 0xE0000000, wdata 0x5A5A5A5A, ready low for 3 cycles → `bus_we`=`bus_mio`=1 for 4 cycles; `mem_ack` at cycle 5; `mem_rdata` unchanged.
- Tie arbitration: after reset, both reqs held continuously → grant order MEM, IF, MEM, IF; `grant_owner` sequence 10, 01, 10, 01 across XFER cycles.
- Timeout: TIMEOUT=15, IF fetch with `bus_ready` stuck at 0 → abort after 15 XFER cycles; `if_ack` at cycle 16 with `if_rdata`=0x00000013; `bus_err`=1 until `err_clr`. A second run raises `bus_ready` in the 15th cycle → normal completion, no error.
- Reset mid-transfer: assert `reset` during the 2nd XFER cycle of a load → outputs 0 immediately, no `mem_ack`; after release, the re-issued load completes normally.
- Error clear race: abort and `err_clr` in the same cycle → `bus_err`=1. `err_clr` alone in a later cycle → `bus_err`=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares the single external memory/MIO port between IF fetches and MEM loads/stores.
// Latency: grant 1 cycle after req, ack 1 cycle after bus_ready; abort acks TIMEOUT+1 cycles after grant.
// Backpressure: requesters stall (stall_if/stall_mem) until their one-cycle ack; bus_ready paces each transfer.
module mem_port_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ack,
    output logic        bus_ale,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_we,
    output logic        bus_mio,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        bus_err,
    input  logic        err_clr,
    output logic [1:0]  grant_owner
);

    localparam int              WCW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCW-1:0]  WAIT_LAST = WCW'(TIMEOUT - 1);
    localparam logic [31:0]     NOP_INSN  = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_IF_XFER  = 2'd1,
        S_MEM_XFER = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic           last_owner_q, last_owner_d;   // 0 = IF, 1 = MEM
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic           we_q, we_d;
    logic [31:0]    if_rdata_q, if_rdata_d;
    logic [31:0]    mem_rdata_q, mem_rdata_d;
    logic           bus_err_q, bus_err_d;

    logic           grant_if;
    logic           grant_mem;
    logic           in_xfer;
    logic           abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_owner_q <= 1'b0;
            wait_cnt_q   <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            wait_cnt_q   <= wait_cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            if_rdata_q   <= if_rdata_d;
            mem_rdata_q  <= mem_rdata_d;
            bus_err_q    <= bus_err_d;
        end
    end

    // On a tie the requester that did not own the last transfer wins.
    assign grant_mem = mem_req & (~if_req | ~last_owner_q);
    assign grant_if  = if_req & ~grant_mem;
    assign in_xfer   = (state_q == S_IF_XFER) || (state_q == S_MEM_XFER);

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        wait_cnt_d   = wait_cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        if_rdata_d   = if_rdata_q;
        mem_rdata_d  = mem_rdata_q;
        abort        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (grant_mem) begin
                    state_d      = S_MEM_XFER;
                    last_owner_d = 1'b1;
                    wait_cnt_d   = '0;
                    addr_d       = mem_addr;
                    wdata_d      = mem_wdata;
                    we_d         = mem_we;
                end else if (grant_if) begin
                    state_d      = S_IF_XFER;
                    last_owner_d = 1'b0;
                    wait_cnt_d   = '0;
                    addr_d       = if_addr;
                    we_d         = 1'b0;
                end
            end
            S_IF_XFER, S_MEM_XFER: begin
                // Ready takes priority over a timeout landing in the same cycle.
                if (bus_ready) begin
                    state_d = S_DONE;
                    if (state_q == S_IF_XFER) begin
                        if_rdata_d = bus_rdata;
                    end else if (!we_q) begin
                        mem_rdata_d = bus_rdata;
                    end
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_DONE;
                    abort   = 1'b1;
                    if (state_q == S_IF_XFER) begin
                        if_rdata_d = NOP_INSN;
                    end else begin
                        mem_rdata_d = '0;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        bus_err_d = abort | (bus_err_q & ~err_clr);
    end

    // wait_cnt is zero only in the first cycle of a transfer.
    assign bus_ale     = in_xfer & (wait_cnt_q == '0);
    assign bus_addr    = addr_q;
    assign bus_wdata   = wdata_q;
    assign bus_we      = (state_q == S_MEM_XFER) & we_q;
    assign bus_mio     = (state_q == S_MEM_XFER);
    assign grant_owner = {state_q == S_MEM_XFER, state_q == S_IF_XFER};

    assign if_ack      = (state_q == S_DONE) & ~last_owner_q;
    assign mem_ack     = (state_q == S_DONE) &  last_owner_q;
    assign if_rdata    = if_rdata_q;
    assign mem_rdata   = mem_rdata_q;
    assign bus_err     = bus_err_q;

    assign stall_if    = if_req  & ~if_ack;
    assign stall_mem   = mem_req & ~mem_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, store with waits, tie order, timeout, reset abort, error clear.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, mem_req, mem_we, bus_ready, err_clr;
    logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
    logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
    logic        if_ack, mem_ack, bus_ale, bus_we, bus_mio;
    logic        stall_if, stall_mem, bus_err;
    logic [1:0]  grant_owner;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .bus_ale(bus_ale), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we),
        .bus_mio(bus_mio), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .bus_err(bus_err), .err_clr(err_clr), .grant_owner(grant_owner)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; if_req = 0; mem_req = 0; mem_we = 0; bus_ready = 0; err_clr = 0;
        if_addr = '0; mem_addr = '0; mem_wdata = '0; bus_rdata = '0;

        // reset state
        cyc(); cyc(); smp();
        chk("rst gown", grant_owner, 0);
        chk("rst ale", bus_ale, 0);
        chk("rst addr", bus_addr, 0);
        chk("rst if_ack", if_ack, 0);
        chk("rst mem_ack", mem_ack, 0);
        chk("rst err", bus_err, 0);
        chk("rst stall_if", stall_if, 0);
        cyc(); reset = 1'b0;

        // single fetch
        cyc(); if_req = 1; if_addr = 32'h100; bus_ready = 1; bus_rdata = 32'h00A00093;
        smp();
        chk("f c0 stall_if", stall_if, 1);
        chk("f c0 ale", bus_ale, 0);
        cyc(); smp();
        chk("f c1 ale", bus_ale, 1);
        chk("f c1 addr", bus_addr, 32'h100);
        chk("f c1 mio", bus_mio, 0);
        chk("f c1 stall_if", stall_if, 1);
        chk("f c1 gown", grant_owner, 1);
        cyc(); smp();
        chk("f c2 if_ack", if_ack, 1);
        chk("f c2 if_rdata", if_rdata, 32'h00A00093);
        chk("f c2 stall_if", stall_if, 0);
        cyc(); if_req = 0; smp();
        chk("f c3 if_ack", if_ack, 0);
        chk("f c3 gown", grant_owner, 0);

        // tie arbitration from reset: MEM, IF, MEM, IF
        reset = 1'b1; cyc(); reset = 1'b0;
        mem_addr = 32'h2000; mem_we = 0; if_addr = 32'h300; mem_req = 1; if_req = 1; bus_ready = 1;
        for (int c = 0; c < 12; c++) begin
            bus_rdata = 32'hC0DE0000 + c;
            smp();
            if (c % 3 == 1) begin
                if (c == 1 || c == 7) begin
                    chk("tie gown mem", grant_owner, 2);
                    chk("tie mio", bus_mio, 1);
                    chk("tie we", bus_we, 0);
                    chk("tie maddr", bus_addr, 32'h2000);
                end else begin
                    chk("tie gown if", grant_owner, 1);
                    chk("tie iaddr", bus_addr, 32'h300);
                end
            end else if (c % 3 == 2) begin
                if (c == 2 || c == 8) begin
                    chk("tie mem_ack", mem_ack, 1);
                    chk("tie if_ack0", if_ack, 0);
                    chk("tie mem_rdata", mem_rdata, 32'hC0DE0000 + c - 1);
                end else begin
                    chk("tie if_ack", if_ack, 1);
                    chk("tie mem_ack0", mem_ack, 0);
                    chk("tie if_rdata", if_rdata, 32'hC0DE0000 + c - 1);
                end
            end else begin
                chk("tie idle gown", grant_owner, 0);
            end
            cyc();
        end
        mem_req = 0; if_req = 0;
        smp();
        chk("tie end gown", grant_owner, 0);

        // store with three wait states
        cyc(); mem_req = 1; mem_we = 1; mem_addr = 32'hE0000000; mem_wdata = 32'h5A5A5A5A; bus_ready = 0;
        for (int c = 1; c <= 4; c++) begin
            cyc(); bus_ready = (c == 4); smp();
            chk("st we", bus_we, 1);
            chk("st mio", bus_mio, 1);
            chk("st ale", bus_ale, (c == 1));
            chk("st addr", bus_addr, 32'hE0000000);
            chk("st wdata", bus_wdata, 32'h5A5A5A5A);
            chk("st stall_mem", stall_mem, 1);
            chk("st ack early", mem_ack, 0);
        end
        cyc(); smp();
        chk("st c5 mem_ack", mem_ack, 1);
        chk("st c5 rdata kept", mem_rdata, 32'hC0DE0007);
        chk("st c5 stall_mem", stall_mem, 0);
        cyc(); mem_req = 0; mem_we = 0; bus_ready = 0;

        // fetch timeout
        cyc(); if_req = 1; if_addr = 32'h400; bus_rdata = 32'hDEADBEEF;
        for (int c = 1; c <= 15; c++) begin
            cyc(); smp();
            chk("to gown", grant_owner, 1);
            chk("to if_ack early", if_ack, 0);
            chk("to err early", bus_err, 0);
        end
        cyc(); smp();
        chk("to c16 if_ack", if_ack, 1);
        chk("to c16 nop", if_rdata, 32'h00000013);
        chk("to c16 err", bus_err, 1);
        cyc(); if_req = 0; smp();
        chk("to c17 err", bus_err, 1);
        cyc(); smp();
        chk("to c18 err", bus_err, 1);
        cyc(); err_clr = 1;
        cyc(); err_clr = 0; smp();
        chk("to cleared", bus_err, 0);

        // ready in the would-be abort cycle
        cyc(); if_req = 1; if_addr = 32'h404; bus_rdata = 32'hFEEDBEEF;
        for (int c = 1; c <= 15; c++) begin
            cyc(); bus_ready = (c == 15); smp();
            chk("rdy if_ack early", if_ack, 0);
        end
        cyc(); smp();
        chk("rdy c16 if_ack", if_ack, 1);
        chk("rdy c16 rdata", if_rdata, 32'hFEEDBEEF);
        chk("rdy c16 err", bus_err, 0);
        cyc(); if_req = 0; bus_ready = 0;

        // load abort racing err_clr: set wins
        cyc(); mem_req = 1; mem_we = 0; mem_addr = 32'h3000;
        for (int c = 1; c <= 15; c++) begin
            cyc(); err_clr = (c == 15); smp();
            chk("race mem_ack early", mem_ack, 0);
        end
        cyc(); err_clr = 0; smp();
        chk("race mem_ack", mem_ack, 1);
        chk("race mem_rdata", mem_rdata, 32'h0);
        chk("race err set", bus_err, 1);
        cyc(); mem_req = 0; err_clr = 1;
        cyc(); err_clr = 0; smp();
        chk("race err clr", bus_err, 0);

        // reset during second cycle of a load
        cyc(); mem_req = 1; mem_addr = 32'h2040; bus_ready = 0;
        cyc(); smp();
        chk("rm c1 ale", bus_ale, 1);
        chk("rm c1 mio", bus_mio, 1);
        cyc(); reset = 1'b1; #1;
        chk("rm mio", bus_mio, 0);
        chk("rm gown", grant_owner, 0);
        chk("rm addr", bus_addr, 0);
        chk("rm wdata", bus_wdata, 0);
        chk("rm we", bus_we, 0);
        chk("rm ale", bus_ale, 0);
        chk("rm if_rdata", if_rdata, 0);
        chk("rm mem_rdata", mem_rdata, 0);
        chk("rm mem_ack", mem_ack, 0);
        chk("rm stall_mem", stall_mem, 1);
        bus_ready = 1; bus_rdata = 32'h600DF00D;
        cyc(); smp();
        chk("rm held ack", mem_ack, 0);
        cyc(); reset = 1'b0; smp();
        chk("rm c0 gown", grant_owner, 0);
        cyc(); smp();
        chk("rm c1 gown", grant_owner, 2);
        chk("rm c1 addr", bus_addr, 32'h2040);
        cyc(); smp();
        chk("rm c2 mem_ack", mem_ack, 1);
        chk("rm c2 rdata", mem_rdata, 32'h600DF00D);
        cyc(); mem_req = 0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
